// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the multi-channel tick scheduler.
// Channel/slot states and the pending config entry live here.
package tick_sched_pkg;

    localparam int NCH_DEF = 4;
    localparam int PW_DEF  = 28;
    localparam int CW_DEF  = $clog2(NCH_DEF);

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } chan_st_e;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } slot_st_e;

    typedef struct packed {
        logic [CW_DEF-1:0] ch;
        logic [PW_DEF-1:0] period;
        logic              en;
    } cfg_entry_t;

    // A zero period can never count, so it is folded into a disable.
    function automatic cfg_entry_t mk_entry(
        input logic [CW_DEF-1:0] ch,
        input logic [PW_DEF-1:0] period,
        input logic              en
    );
        cfg_entry_t e;
        e.ch     = ch;
        e.period = period;
        e.en     = en & (period != '0);
        return e;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One clock-enable channel: period counter, boundary detect, load port.
// A load replaces period/enable and restarts the count from zero.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [PW-1:0] per_i,
    input  logic          en_i,
    output logic          tick_o,
    output logic          phase_o,
    output logic          en_o
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] per_q;
    chan_st_e      st_q;
    logic          run;
    logic          last;

    assign run  = (st_q == RUN);
    assign last = run && (cnt_q == (per_q - PW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            per_q <= '0;
            st_q  <= OFF;
        end else if (load_i) begin
            per_q <= per_i;
            cnt_q <= '0;
            st_q  <= en_i ? RUN : OFF;
        end else begin
            unique case (st_q)
                OFF: cnt_q <= '0;
                RUN: cnt_q <= last ? '0 : cnt_q + PW'(1);
                default: cnt_q <= '0;
            endcase
        end
    end

    assign tick_o  = last;
    assign phase_o = run && (cnt_q < (per_q >> 1));
    assign en_o    = run;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel programmable tick generator with a single config slot.
// Updates to a running channel wait for its period boundary.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = PW_DEF,
    parameter int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    input  logic           cfg_en,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] phase,
    output logic [NCH-1:0] ch_en
);

    slot_st_e   slot_q;
    cfg_entry_t entry_q;
    cfg_entry_t entry_d;
    logic       accept;
    logic       tgt_en;
    logic       tgt_last;
    logic       retire;
    logic       apply;
    logic [NCH-1:0] load;

    assign cfg_ready = (slot_q == EMPTY) & ~rst;
    assign accept    = cfg_valid & cfg_ready;
    assign entry_d   = mk_entry(cfg_ch, cfg_period, cfg_en);

    assign tgt_en   = ch_en[entry_q.ch];
    assign tgt_last = tick[entry_q.ch];

    // OFF targets retire at once; RUN targets only on their last cycle.
    assign retire = (slot_q == HELD) & (~tgt_en | tgt_last);
    assign apply  = retire & (tgt_en | entry_q.en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= EMPTY;
            entry_q <= '0;
        end else begin
            unique case (slot_q)
                EMPTY: begin
                    if (accept) begin
                        entry_q <= entry_d;
                        slot_q  <= HELD;
                    end
                end
                HELD: begin
                    if (retire) slot_q <= EMPTY;
                end
                default: slot_q <= EMPTY;
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign load[i] = apply & (entry_q.ch == CW'(i));

        tick_channel #(
            .PW(PW)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[i]),
            .per_i  (entry_q.period),
            .en_i   (entry_q.en),
            .tick_o (tick[i]),
            .phase_o(phase[i]),
            .en_o   (ch_en[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_tick_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [27:0] cfg_period;
    logic        cfg_en;
    logic [3:0]  tick;
    logic [3:0]  phase;
    logic [3:0]  ch_en;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;

    tick_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_en    (cfg_en),
        .tick      (tick),
        .phase     (phase),
        .ch_en     (ch_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs,
                        input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic write(input int ch, input int per, input logic en);
        int n;
        cfg_ch     = 2'(ch);
        cfg_period = 28'(per);
        cfg_en     = en;
        cfg_valid  = 1'b1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        chk("wr_ready_wait", n < 50, 1'b1);
        step();
        cfg_valid = 1'b0;
    endtask

    function automatic logic t0_exp();
        return ((cyc - c0) % 4) == 3;
    endfunction

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_en     = 1'b0;

        // reset state
        step();
        step();
        chk("rst_ready", cfg_ready, 1'b0);
        chk4("rst_tick", tick, 4'b0000);
        chk4("rst_phase", phase, 4'b0000);
        chk4("rst_en", ch_en, 4'b0000);
        rst = 1'b0;
        #1;
        chk("rel_ready", cfg_ready, 1'b1);

        // ch0 per=4 from OFF
        write(0, 4, 1'b1);
        chk("t1_ready_lo", cfg_ready, 1'b0);
        chk("t1_en_pre", ch_en[0], 1'b0);
        chk("t1_tick_pre", tick[0], 1'b0);
        step();
        c0 = cyc;
        chk("t1_en", ch_en[0], 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t1_ready", cfg_ready, 1'b1);
            chk("t1_tick", tick[0], (k % 4) == 3);
            chk("t1_phase", phase[0], (k % 4) < 2);
            step();
        end

        // ch1 per=10, retarget to per=3 at cnt=2
        write(1, 10, 1'b1);
        step();
        step();
        chk("t2_en", ch_en[1], 1'b1);
        write(1, 3, 1'b1);
        for (int j = 0; j < 8; j++) begin
            chk("t2_ready_lo", cfg_ready, 1'b0);
            chk("t2_tick_old", tick[1], j == 7);
            chk("t2_ch0", tick[0], t0_exp());
            step();
        end
        for (int j = 0; j < 6; j++) begin
            chk("t2_ready_hi", cfg_ready, 1'b1);
            chk("t2_tick_new", tick[1], (j % 3) == 2);
            chk("t2_ch0b", tick[0], t0_exp());
            step();
        end

        // ch2 per=6 then disabled via per=0
        write(2, 6, 1'b1);
        step();
        write(2, 0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            chk("t3_en_on", ch_en[2], 1'b1);
            chk("t3_tick_last", tick[2], j == 4);
            step();
        end
        for (int j = 0; j < 4; j++) begin
            chk("t3_en_off", ch_en[2], 1'b0);
            chk("t3_tick_off", tick[2], 1'b0);
            chk("t3_phase_off", phase[2], 1'b0);
            chk("t3_ch0", tick[0], t0_exp());
            step();
        end

        // disable of an already OFF channel
        write(2, 5, 1'b0);
        chk("t3b_ready_lo", cfg_ready, 1'b0);
        step();
        chk("t3b_ready_hi", cfg_ready, 1'b1);
        chk("t3b_en", ch_en[2], 1'b0);

        // back-to-back writes to ch3 with valid held
        cfg_ch     = 2'd3;
        cfg_period = 28'd5;
        cfg_en     = 1'b1;
        cfg_valid  = 1'b1;
        step();
        chk("t4_ready_lo1", cfg_ready, 1'b0);
        cfg_period = 28'd2;
        step();
        chk("t4_en", ch_en[3], 1'b1);
        chk("t4_ready_hi1", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("t4_ready_lo2", cfg_ready, 1'b0);
        for (int j = 0; j < 4; j++) begin
            chk("t4_tick_old", tick[3], j == 3);
            chk("t4_ready_wait", cfg_ready, 1'b0);
            step();
        end
        for (int j = 0; j < 6; j++) begin
            chk("t4_tick_new", tick[3], (j % 2) == 1);
            chk("t4_phase_new", phase[3], (j % 2) == 0);
            chk("t4_ready_hi2", cfg_ready, 1'b1);
            chk("t4_ch0", tick[0], t0_exp());
            step();
        end

        // reset with a HELD entry for running ch1
        write(1, 7, 1'b1);
        chk("t5_held", cfg_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk4("t5_tick", tick, 4'b0000);
        chk4("t5_phase", phase, 4'b0000);
        chk4("t5_en", ch_en, 4'b0000);
        chk("t5_ready", cfg_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_ready_rel", cfg_ready, 1'b1);
        for (int j = 0; j < 10; j++) begin
            chk4("t5_tick_q", tick, 4'b0000);
            chk4("t5_en_q", ch_en, 4'b0000);
            step();
        end

        // per=1 on ch0
        write(0, 1, 1'b1);
        chk("t6_tick_pre", tick[0], 1'b0);
        step();
        for (int j = 0; j < 5; j++) begin
            chk("t6_tick", tick[0], 1'b1);
            chk("t6_phase", phase[0], 1'b0);
            chk("t6_en", ch_en[0], 1'b1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
